lsu_bus_adapter: RTL and testbench

// - Multi-cycle load/store unit between the MEM stage and the data-memory bus.
// - Decodes common:: access types (SB/SH/SW/LB/LBU/LH/LHU/LW); anything else is a non-memory op.
// - Aligns and strobes store data onto a BUS_W-wide bus and runs a valid/ready request channel.
// - Extracts and sign/zero-extends load data, detects misalignment and bus timeouts.

---
 rtl/lsu_bus_adapter.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_lsu_bus_adapter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_adapter.sv
// Load/store unit bridging the MEM stage to a valid/ready data-memory bus.
// Aligns store data and byte strobes onto a BUS_W-wide bus, extracts and
// sign/zero-extends load data, flags misaligned accesses and bus timeouts.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN -- when defined, misaligned
// accesses are carried out on the bus (split into two beats when they cross
// a bus word) instead of completing with a misalignment error.

package common;
    typedef enum logic [3:0] {
        MEM_NONE = 4'h0,
        MEM_LB   = 4'h1,
        MEM_LH   = 4'h2,
        MEM_LW   = 4'h3,
        MEM_LBU  = 4'h4,
        MEM_LHU  = 4'h5,
        MEM_SB   = 4'h6,
        MEM_SH   = 4'h7,
        MEM_SW   = 4'h8
    } mem_type_e;
endpackage

module lsu_bus_adapter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned BUS_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_type,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [BUS_W-1:0]      mem_wdata,
    output logic [BUS_W/8-1:0]    mem_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [BUS_W-1:0]      mem_rdata
);
    import common::*;

    localparam int unsigned BUS_B   = BUS_W / 8;
    localparam int unsigned OFF_W   = $clog2(BUS_B);
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
`ifdef LSU_MISALIGN_SPLIT_EN
    // Two bus words of alignment room so a crossing access lands in the upper half.
    localparam int unsigned SPAN    = 2;
`else
    localparam int unsigned SPAN    = 1;
`endif

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_TO  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
`ifdef LSU_MISALIGN_SPLIT_EN
        , S_REQ2,
        S_WAIT2
`endif
    } state_e;

    state_e                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_we;
    logic [1:0]                r_size;
    logic                      r_sign;
    logic [OFF_W-1:0]          r_off;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic                      r_cross;
    logic [BUS_W-1:0]          r_lo;
    logic [BUS_W-1:0]          r_wdata_hi;
    logic [BUS_B-1:0]          r_strb_hi;
`endif

    logic                      w_is_mem;
    logic                      w_we;
    logic                      w_sign;
    logic [1:0]                w_size;
    logic [3:0]                w_mask;
    logic [OFF_W-1:0]          w_off;
    logic [ADDR_W-1:0]         w_base;
    logic [SPAN*BUS_B-1:0]     w_strb_wide;
    logic [SPAN*BUS_W-1:0]     w_wdata_wide;
    logic                      w_fast;
    logic                      w_timeout;
    logic [SPAN*BUS_W-1:0]     w_rd_single;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic                      w_cross;
    logic [SPAN*BUS_W-1:0]     w_rd_pair;
`else
    logic                      w_misal;
`endif

    // Shift the addressed bytes down, then truncate and extend to the access size.
    function automatic logic [31:0] f_load(input logic [SPAN*BUS_W-1:0] wide,
                                           input logic [OFF_W-1:0]      off,
                                           input logic [1:0]            size,
                                           input logic                  sgn);
        logic [31:0] x;
        x = 32'(wide >> {off, 3'b000});
        case (size)
            2'd0:    x = {{24{sgn & x[7]}}, x[7:0]};
            2'd1:    x = {{16{sgn & x[15]}}, x[15:0]};
            default: ;
        endcase
        return x;
    endfunction

    // Decode the incoming access type and pre-compute bus alignment for it.
    always_comb begin
        w_is_mem = 1'b1;
        w_we     = 1'b0;
        w_sign   = 1'b0;
        w_size   = 2'd0;
        case (req_type)
            MEM_LB:  w_sign = 1'b1;
            MEM_LBU: ;
            MEM_LH:  begin w_size = 2'd1; w_sign = 1'b1; end
            MEM_LHU: w_size = 2'd1;
            MEM_LW:  w_size = 2'd2;
            MEM_SB:  w_we = 1'b1;
            MEM_SH:  begin w_we = 1'b1; w_size = 2'd1; end
            MEM_SW:  begin w_we = 1'b1; w_size = 2'd2; end
            default: w_is_mem = 1'b0;
        endcase
        case (w_size)
            2'd0:    w_mask = 4'h1;
            2'd1:    w_mask = 4'h3;
            default: w_mask = 4'hF;
        endcase
        w_off        = req_addr[OFF_W-1:0];
        w_base       = req_addr & ~ADDR_W'(BUS_B - 1);
        w_strb_wide  = (SPAN*BUS_B)'(w_mask) << w_off;
        w_wdata_wide = (SPAN*BUS_W)'(req_wdata) << {w_off, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
        w_cross      = |w_strb_wide[SPAN*BUS_B-1:BUS_B];
        w_fast       = !w_is_mem;
`else
        w_misal      = ((w_size == 2'd1) && req_addr[0]) ||
                       ((w_size == 2'd2) && (req_addr[1:0] != 2'b00));
        w_fast       = !w_is_mem || w_misal;
`endif
    end

    // Timeout is the last permitted WAIT cycle passing with no response.
    always_comb begin
        w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TO_LAST));
        w_rd_single = (SPAN*BUS_W)'(mem_rdata);
`ifdef LSU_MISALIGN_SPLIT_EN
        w_rd_pair   = {mem_rdata, r_lo};
`endif
    end

    // Request FSM with all handshake and response outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= '0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_size        <= '0;
            r_sign        <= 1'b0;
            r_off         <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_cross       <= 1'b0;
            r_lo          <= '0;
            r_wdata_hi    <= '0;
            r_strb_hi     <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        r_we      <= w_we;
                        r_size    <= w_size;
                        r_sign    <= w_sign;
                        r_off     <= w_off;
                        if (w_fast) begin
                            r_state   <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_err   <= w_is_mem ? ERR_MIS : ERR_OK;
                        end else begin
                            r_state       <= S_REQ;
                            r_cnt         <= '0;
                            mem_req_valid <= 1'b1;
                            mem_we        <= w_we;
                            mem_addr      <= w_base;
                            mem_wdata     <= w_we ? w_wdata_wide[BUS_W-1:0] : '0;
                            mem_wstrb     <= w_we ? w_strb_wide[BUS_B-1:0] : '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                            r_cross       <= w_cross;
                            r_wdata_hi    <= w_we ? w_wdata_wide[SPAN*BUS_W-1:BUS_W] : '0;
                            r_strb_hi     <= w_we ? w_strb_wide[SPAN*BUS_B-1:BUS_B] : '0;
`endif
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        // Low beat done; keep its data and issue the high beat.
                        if (r_cross) begin
                            r_lo          <= mem_rdata;
                            r_cnt         <= '0;
                            r_state       <= S_REQ2;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= mem_addr + ADDR_W'(BUS_B);
                            mem_wdata     <= r_wdata_hi;
                            mem_wstrb     <= r_strb_hi;
                        end else
`endif
                        begin
                            r_state   <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= ERR_OK;
                            rsp_rdata <= r_we ? '0 : f_load(w_rd_single, r_off, r_size, r_sign);
                        end
                    end else if (w_timeout) begin
                        r_state   <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_TO;
                        rsp_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                S_REQ2: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= S_WAIT2;
                    end
                end
                S_WAIT2: begin
                    if (mem_rsp_valid) begin
                        r_state   <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_OK;
                        rsp_rdata <= r_we ? '0 : f_load(w_rd_pair, r_off, r_size, r_sign);
                    end else if (w_timeout) begin
                        r_state   <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_TO;
                        rsp_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                S_DONE: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_rdata <= '0;
                    rsp_err   <= '0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench for lsu_bus_adapter (default build, BUS_W=32, TIMEOUT_CYCLES=4).
// Expected responses are queued when a request is driven and checked by a
// monitor when rsp_valid pulses; bus-side fields are checked inline.

module tb_lsu_bus_adapter;
    import common::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic [1:0]  err;
        logic [31:0] rdata;
    } exp_t;

    exp_t q_exp[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic prev_rsp = 1'b0;

    lsu_bus_adapter #(
        .ADDR_W(32),
        .BUS_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_type(req_type),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid === 1'b1) begin
            chk("rsp_single_cycle", prev_rsp, 1'b0);
            chk("rsp_expected", q_exp.size() != 0, 1'b1);
            if (q_exp.size() != 0) begin
                exp_t e;
                e = q_exp.pop_front();
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
        prev_rsp = (rsp_valid === 1'b1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd);
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = a;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_type  = 4'h0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (req_ready !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("idle_return", req_ready, 1'b1);
    endtask

    task automatic bus_serve(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] st, input logic [31:0] rd, input int hold);
        int k;
        k = 0;
        while (mem_req_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mreq_seen", mem_req_valid, 1'b1);
        chk("busy_not_ready", req_ready, 1'b0);
        chk("mem_we", mem_we, we);
        chk("mem_addr", mem_addr, a);
        chk("mem_wstrb", mem_wstrb, st);
        if (we) chk("mem_wdata", mem_wdata, wd);
        for (int i = 0; i < hold; i++) begin
            mem_req_ready = 1'b0;
            @(negedge clk);
            chk("mreq_hold", {mem_req_valid, mem_we, mem_addr, mem_wstrb}, {1'b1, we, a, st});
            if (we) chk("mreq_hold_wdata", mem_wdata, wd);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("mreq_dropped", mem_req_valid, 1'b0);
        chk("no_early_rsp", rsp_valid, 1'b0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = rd;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        chk("rsp_latency", rsp_valid, 1'b1);
    endtask

    task automatic bus_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                          input logic we, input logic [31:0] ea, input logic [31:0] ewd,
                          input logic [3:0] est, input logic [31:0] rd, input logic [31:0] erd,
                          input int hold);
        q_exp.push_back('{err: 2'b00, rdata: erd});
        issue(t, a, wd);
        chk("mreq_t_plus_1", mem_req_valid, 1'b1);
        bus_serve(we, ea, ewd, est, rd, hold);
        wait_idle();
    endtask

    task automatic fast_op(input logic [3:0] t, input logic [31:0] a, input logic [1:0] err);
        q_exp.push_back('{err: err, rdata: 32'h0});
        issue(t, a, 32'hFFFF_FFFF);
        chk("fast_rsp_t1", rsp_valid, 1'b1);
        chk("fast_no_bus", mem_req_valid, 1'b0);
        @(negedge clk);
        chk("fast_rsp_end", rsp_valid, 1'b0);
        chk("fast_no_bus2", mem_req_valid, 1'b0);
        chk("fast_ready", req_ready, 1'b1);
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_type      = '0;
        req_addr      = '0;
        req_wdata     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_wstrb", mem_wstrb, 4'h0);
        chk("rst_rsp_err", rsp_err, 2'b00);

        // Stray bus response while idle
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1234_5678;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("stray_idle_no_rsp", rsp_valid, 1'b0);
        chk("stray_idle_ready", req_ready, 1'b1);

        // Stores: byte-lane alignment and strobes
        bus_op(MEM_SB, 32'h1003, 32'h0000_00AB, 1'b1, 32'h1000, 32'hAB00_0000, 4'b1000, 32'h0, 32'h0, 2);
        bus_op(MEM_SH, 32'h1002, 32'h0000_1234, 1'b1, 32'h1000, 32'h1234_0000, 4'b1100, 32'h0, 32'h0, 0);
        bus_op(MEM_SW, 32'h1004, 32'hDEAD_BEEF, 1'b1, 32'h1004, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h0, 1);
        bus_op(MEM_SB, 32'h1001, 32'h0000_0055, 1'b1, 32'h1000, 32'h0000_5500, 4'b0010, 32'h0, 32'h0, 0);

        // Loads: extraction and sign/zero extension
        bus_op(MEM_LB,  32'h2002, 32'h0, 1'b0, 32'h2000, 32'h0, 4'b0000, 32'h0080_0000, 32'hFFFF_FF80, 0);
        bus_op(MEM_LBU, 32'h2002, 32'h0, 1'b0, 32'h2000, 32'h0, 4'b0000, 32'h0080_0000, 32'h0000_0080, 1);
        bus_op(MEM_LB,  32'h2001, 32'h0, 1'b0, 32'h2000, 32'h0, 4'b0000, 32'h0000_7F00, 32'h0000_007F, 0);
        bus_op(MEM_LH,  32'h2002, 32'h0, 1'b0, 32'h2000, 32'h0, 4'b0000, 32'h8001_0000, 32'hFFFF_8001, 0);
        bus_op(MEM_LHU, 32'h2002, 32'h0, 1'b0, 32'h2000, 32'h0, 4'b0000, 32'h8001_0000, 32'h0000_8001, 0);
        bus_op(MEM_LH,  32'h2000, 32'h0, 1'b0, 32'h2000, 32'h0, 4'b0000, 32'h1234_7FFE, 32'h0000_7FFE, 0);
        bus_op(MEM_LW,  32'h3000, 32'h0, 1'b0, 32'h3000, 32'h0, 4'b0000, 32'hCAFE_F00D, 32'hCAFE_F00D, 2);

        // Misaligned and non-memory ops complete without bus traffic
        fast_op(MEM_LW, 32'h3002, 2'b01);
        fast_op(MEM_LH, 32'h2001, 2'b01);
        fast_op(MEM_SW, 32'h1001, 2'b01);
        fast_op(MEM_SH, 32'h1003, 2'b01);
        fast_op(4'hF,   32'h3002, 2'b00);
        fast_op(MEM_NONE, 32'h0, 2'b00);

        // Timeout: four WAIT cycles with no response, then a late response
        q_exp.push_back('{err: 2'b10, rdata: 32'h0});
        issue(MEM_LW, 32'h4000, 32'h0);
        chk("to_mreq", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_waiting", rsp_valid, 1'b0);
            @(negedge clk);
        end
        chk("to_rsp", rsp_valid, 1'b1);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("late_rsp_ignored0", rsp_valid, 1'b0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        @(negedge clk);
        chk("late_rsp_ignored1", rsp_valid, 1'b0);
        chk("late_rsp_ready", req_ready, 1'b1);

        // Reset in the middle of a WAIT
        issue(MEM_LW, 32'h5000, 32'h0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", req_ready, 1'b1);
        chk("midrst_mreq", mem_req_valid, 1'b0);
        chk("midrst_rsp", rsp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h7777_7777;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("postrst_ready", req_ready, 1'b1);
        chk("postrst_mreq", mem_req_valid, 1'b0);
        @(negedge clk);
        chk("postrst_no_rsp", rsp_valid, 1'b0);

        // Normal traffic still works after reset
        bus_op(MEM_LBU, 32'h6003, 32'h0, 1'b0, 32'h6000, 32'h0, 4'b0000, 32'hF100_0000, 32'h0000_00F1, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
